result_bus_arbiter: RTL and testbench

- Shares a single result broadcast bus (CDB) between two producers: the ALU result port and the memory-load result port.
- Each producer gets a small FIFO. Round-robin grant drives one registered broadcast per cycle to ROB, RS and LSB.
- Removes the same-cycle collision between ALU and memory-controller results.
- Sits between alu / memory_controller and the consumers.

---
 rtl/result_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_result_bus_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: merges ALU and load results onto one registered CDB broadcast.
// Each source has a small FIFO with bypass; a round-robin grant picks one winner per cycle.

module result_bus_arbiter_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         almost_full,
  output logic         drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             afull_q, afull_d;
  logic             do_push, do_pop;

  assign empty       = (cnt_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign almost_full = afull_q;
  // A push into a completely full FIFO with no simultaneous pop is lost.
  assign drop        = push && !pop && (cnt_q == CNT_FULL);
  assign do_push     = push && !drop;
  assign do_pop      = pop && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    afull_d = (cnt_d >= CNT_AFULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      afull_q  <= 1'b0;
    end else if (en) begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      afull_q  <= afull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en && !clr && do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// Handshake: a producer offers an item for exactly one cycle with its valid bit
// (alu_ready / mem_data_ready); there is no per-item stall. *_full tells the
// producer to stop issuing and leaves one slot for an item already in flight.
// cdb_ready qualifies cdb_val/cdb_id/cdb_src for one cycle; consumers cannot stall it.
module result_bus_arbiter #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                alu_ready,
  input  logic [XLEN-1:0]     alu_res,
  input  logic [ID_WIDTH-1:0] alu_id,
  output logic                alu_full,
  input  logic                mem_data_ready,
  input  logic [XLEN-1:0]     mem_data,
  input  logic [ID_WIDTH-1:0] mem_id,
  output logic                mem_full,
  output logic                cdb_ready,
  output logic [XLEN-1:0]     cdb_val,
  output logic [ID_WIDTH-1:0] cdb_id,
  output logic                cdb_src,
  output logic                err_overflow
);
  localparam int PW = ID_WIDTH + XLEN;

  logic [PW-1:0]       alu_head, mem_head, alu_pay, mem_pay;
  logic                alu_empty, mem_empty;
  logic                alu_drop, mem_drop;
  logic                alu_cand, mem_cand, any_cand;
  logic                grant_mem, alu_win, mem_win;
  logic                alu_push, alu_pop, mem_push, mem_pop;

  logic                cdb_ready_q, cdb_ready_d;
  logic [XLEN-1:0]     cdb_val_q, cdb_val_d;
  logic [ID_WIDTH-1:0] cdb_id_q, cdb_id_d;
  logic                cdb_src_q, cdb_src_d;
  logic                last_grant_q, last_grant_d;
  logic                err_q, err_d;

  result_bus_arbiter_fifo #(.W(PW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .en          (rdy),
    .clr         (flush),
    .push        (alu_push),
    .pop         (alu_pop),
    .wdata       ({alu_id, alu_res}),
    .head        (alu_head),
    .empty       (alu_empty),
    .almost_full (alu_full),
    .drop        (alu_drop)
  );

  result_bus_arbiter_fifo #(.W(PW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk         (clk),
    .rst         (rst),
    .en          (rdy),
    .clr         (flush),
    .push        (mem_push),
    .pop         (mem_pop),
    .wdata       ({mem_id, mem_data}),
    .head        (mem_head),
    .empty       (mem_empty),
    .almost_full (mem_full),
    .drop        (mem_drop)
  );

  // An incoming item only bypasses when its FIFO is empty, which keeps per-source order.
  always_comb begin
    alu_cand  = !alu_empty || alu_ready;
    mem_cand  = !mem_empty || mem_data_ready;
    any_cand  = alu_cand || mem_cand;
    alu_pay   = alu_empty ? {alu_id, alu_res} : alu_head;
    mem_pay   = mem_empty ? {mem_id, mem_data} : mem_head;
    grant_mem = (alu_cand && mem_cand) ? !last_grant_q : mem_cand;
    alu_win   = any_cand && !grant_mem;
    mem_win   = any_cand && grant_mem;
    alu_pop   = alu_win && !alu_empty;
    mem_pop   = mem_win && !mem_empty;
    alu_push  = alu_ready && !(alu_win && alu_empty);
    mem_push  = mem_data_ready && !(mem_win && mem_empty);
  end

  always_comb begin
    cdb_ready_d  = cdb_ready_q;
    cdb_val_d    = cdb_val_q;
    cdb_id_d     = cdb_id_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    if (flush) begin
      cdb_ready_d = 1'b0;
    end else begin
      cdb_ready_d = any_cand;
      if (any_cand) begin
        {cdb_id_d, cdb_val_d} = grant_mem ? mem_pay : alu_pay;
        cdb_src_d             = grant_mem;
      end
      if (alu_cand && mem_cand) last_grant_d = grant_mem;
      if (alu_drop || mem_drop) err_d = 1'b1;
    end
  end

  // last_grant resets to MEM so the ALU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_ready_q  <= 1'b0;
      cdb_val_q    <= '0;
      cdb_id_q     <= '0;
      cdb_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else if (rdy) begin
      cdb_ready_q  <= cdb_ready_d;
      cdb_val_q    <= cdb_val_d;
      cdb_id_q     <= cdb_id_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign cdb_ready    = cdb_ready_q;
  assign cdb_val      = cdb_val_q;
  assign cdb_id       = cdb_id_q;
  assign cdb_src      = cdb_src_q;
  assign err_overflow = err_q;
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: a queue-based reference model predicts every CDB cycle,
// and scenario tasks add targeted checks on top.

module tb_result_bus_arbiter;
  localparam int XLEN     = 32;
  localparam int ID_WIDTH = 4;
  localparam int DEPTH    = 4;
  localparam int PW       = ID_WIDTH + XLEN;
  localparam int EW       = 2 + ID_WIDTH + XLEN + 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                rdy = 1'b1;
  logic                flush = 1'b0;
  logic                alu_ready = 1'b0;
  logic [XLEN-1:0]     alu_res = '0;
  logic [ID_WIDTH-1:0] alu_id = '0;
  logic                alu_full;
  logic                mem_data_ready = 1'b0;
  logic [XLEN-1:0]     mem_data = '0;
  logic [ID_WIDTH-1:0] mem_id = '0;
  logic                mem_full;
  logic                cdb_ready;
  logic [XLEN-1:0]     cdb_val;
  logic [ID_WIDTH-1:0] cdb_id;
  logic                cdb_src;
  logic                err_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected per-cycle outputs: {ready, src, id, val, alu_full, mem_full, err}
  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] m_alu_q[$];
  logic [PW-1:0] m_mem_q[$];
  logic                m_last, m_ready, m_src, m_alu_full, m_mem_full, m_err;
  logic [XLEN-1:0]     m_val;
  logic [ID_WIDTH-1:0] m_id;
  logic                m_mem_dropped;
  logic [ID_WIDTH-1:0] m_mem_drop_id;
  logic                mem_seen [16];

  result_bus_arbiter #(.XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .alu_ready      (alu_ready),
    .alu_res        (alu_res),
    .alu_id         (alu_id),
    .alu_full       (alu_full),
    .mem_data_ready (mem_data_ready),
    .mem_data       (mem_data),
    .mem_id         (mem_id),
    .mem_full       (mem_full),
    .cdb_ready      (cdb_ready),
    .cdb_val        (cdb_val),
    .cdb_id         (cdb_id),
    .cdb_src        (cdb_src),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_alu_q.delete();
    m_mem_q.delete();
    exp_q.delete();
    m_last = 1'b1;
    m_ready = 1'b0; m_src = 1'b0; m_val = '0; m_id = '0;
    m_alu_full = 1'b0; m_mem_full = 1'b0; m_err = 1'b0;
  endtask

  // One clock of stimulus: score the previous cycle, drive inputs, advance the model.
  task automatic step(input logic r, input logic f,
                      input logic av, input logic [XLEN-1:0] ares, input logic [ID_WIDTH-1:0] aid,
                      input logic mv, input logic [XLEN-1:0] md, input logic [ID_WIDTH-1:0] mid);
    logic          a_c, m_c, win_mem, a_byp, m_byp;
    logic [PW-1:0] a_p, m_p;
    logic [EW-1:0] e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({cdb_ready, cdb_src, cdb_id, cdb_val, alu_full, mem_full, err_overflow} !== e) begin
        tests_failed++;
        $display("FAIL scoreboard @%0t: got rdy=%0b src=%0b id=%0h val=%h afull=%0b mfull=%0b err=%0b, expected rdy=%0b src=%0b id=%0h val=%h afull=%0b mfull=%0b err=%0b",
                 $time, cdb_ready, cdb_src, cdb_id, cdb_val, alu_full, mem_full, err_overflow,
                 e[EW-1], e[EW-2], e[3+XLEN +: ID_WIDTH], e[3 +: XLEN], e[2], e[1], e[0]);
      end
      if (cdb_ready && cdb_src) mem_seen[cdb_id] = 1'b1;
    end
    #1;
    rdy = r; flush = f;
    alu_ready = av; alu_res = ares; alu_id = aid;
    mem_data_ready = mv; mem_data = md; mem_id = mid;
    if (r) begin
      if (f) begin
        m_alu_q.delete();
        m_mem_q.delete();
        m_ready = 1'b0; m_alu_full = 1'b0; m_mem_full = 1'b0;
      end else begin
        a_c = (m_alu_q.size() != 0) || av;
        m_c = (m_mem_q.size() != 0) || mv;
        a_p = (m_alu_q.size() != 0) ? m_alu_q[0] : {aid, ares};
        m_p = (m_mem_q.size() != 0) ? m_mem_q[0] : {mid, md};
        win_mem = (a_c && m_c) ? !m_last : m_c;
        if (a_c && m_c) m_last = win_mem;
        m_ready = a_c || m_c;
        if (m_ready) begin
          m_src = win_mem;
          {m_id, m_val} = win_mem ? m_p : a_p;
        end
        a_byp = m_ready && !win_mem && (m_alu_q.size() == 0);
        m_byp = m_ready && win_mem && (m_mem_q.size() == 0);
        if (m_ready && !win_mem && !a_byp) void'(m_alu_q.pop_front());
        if (m_ready && win_mem && !m_byp) void'(m_mem_q.pop_front());
        if (av && !a_byp) begin
          if (m_alu_q.size() == DEPTH) m_err = 1'b1;
          else m_alu_q.push_back({aid, ares});
        end
        if (mv && !m_byp) begin
          if (m_mem_q.size() == DEPTH) begin
            m_err = 1'b1;
            if (!m_mem_dropped) m_mem_drop_id = mid;
            m_mem_dropped = 1'b1;
          end else m_mem_q.push_back({mid, md});
        end
        m_alu_full = (m_alu_q.size() >= DEPTH - 1);
        m_mem_full = (m_mem_q.size() >= DEPTH - 1);
      end
    end
    exp_q.push_back({m_ready, m_src, m_id, m_val, m_alu_full, m_mem_full, m_err});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if ({cdb_ready, cdb_src, cdb_id, cdb_val} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cdb: got rdy=%0b src=%0b id=%0h val=%h, expected all 0", cdb_ready, cdb_src, cdb_id, cdb_val);
    end
    tests_run++;
    if ({alu_full, mem_full, err_overflow} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, expected 000", {alu_full, mem_full, err_overflow});
    end
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      tests_run++;
      if (cdb_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_ready[%0d]: got %0b, expected 0", i, cdb_ready);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 1'b1, 32'h11, 4'd1, 1'b1, 32'h22, 4'd2);
    idle();
    tests_run++;
    if ({cdb_ready, cdb_src, cdb_id, cdb_val} !== {1'b1, 1'b0, 4'd1, 32'h11}) begin
      tests_failed++;
      $display("FAIL simul_first: got rdy=%0b src=%0b id=%0h val=%h, expected 1 0 1 11", cdb_ready, cdb_src, cdb_id, cdb_val);
    end
    idle();
    tests_run++;
    if ({cdb_ready, cdb_src, cdb_id, cdb_val} !== {1'b1, 1'b1, 4'd2, 32'h22}) begin
      tests_failed++;
      $display("FAIL simul_second: got rdy=%0b src=%0b id=%0h val=%h, expected 1 1 2 22", cdb_ready, cdb_src, cdb_id, cdb_val);
    end
    idle();
    tests_run++;
    if (cdb_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_after: got %0b, expected 0", cdb_ready);
    end
  endtask

  task automatic test_alu_bypass();
    step(1'b1, 1'b0, 1'b1, 32'h0000_00AA, 4'd3, 1'b0, '0, '0);
    idle();
    tests_run++;
    if ({cdb_ready, cdb_src, cdb_id, cdb_val} !== {1'b1, 1'b0, 4'd3, 32'h0000_00AA}) begin
      tests_failed++;
      $display("FAIL alu_bypass: got rdy=%0b src=%0b id=%0h val=%h, expected 1 0 3 000000aa", cdb_ready, cdb_src, cdb_id, cdb_val);
    end
    idle();
    tests_run++;
    if (cdb_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_bypass_after: got %0b, expected 0", cdb_ready);
    end
  endtask

  task automatic test_contention();
    logic first, exp_src;
    first = !m_last;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) step(1'b1, 1'b0, 1'b1, 32'hA0 + i, 4'(i), 1'b1, 32'hB0 + i, 4'(i + 8));
      else idle();
      if (i > 0) begin
        exp_src = ((i - 1) % 2 == 1) ? !first : first;
        tests_run++;
        if ({cdb_ready, cdb_src} !== {1'b1, exp_src}) begin
          tests_failed++;
          $display("FAIL contention_src[%0d]: got rdy=%0b src=%0b, expected rdy=1 src=%0b", i - 1, cdb_ready, cdb_src, exp_src);
        end
      end
    end
    tests_run++;
    if ({alu_full, mem_full} !== 2'b11) begin
      tests_failed++;
      $display("FAIL contention_full: got %b, expected 11", {alu_full, mem_full});
    end
    repeat (8) idle();
    tests_run++;
    if ({cdb_ready, alu_full, mem_full} !== 3'b000) begin
      tests_failed++;
      $display("FAIL contention_drain: got %b, expected 000", {cdb_ready, alu_full, mem_full});
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b1, 32'hD0 + i, 4'(i), 1'b1, 32'hE0 + i, 4'(i + 8));
    step(1'b1, 1'b1, 1'b1, 32'hEE, 4'd15, 1'b0, '0, '0);
    tests_run++;
    if ({alu_full, mem_full} !== 2'b11) begin
      tests_failed++;
      $display("FAIL flush_backlog: got %b, expected 11", {alu_full, mem_full});
    end
    idle();
    tests_run++;
    if ({cdb_ready, alu_full, mem_full} !== 3'b000) begin
      tests_failed++;
      $display("FAIL flush_clear: got %b, expected 000", {cdb_ready, alu_full, mem_full});
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      tests_run++;
      if (cdb_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_quiet[%0d]: got %0b, expected 0", i, cdb_ready);
      end
    end
  endtask

  task automatic test_rdy_gating();
    step(1'b1, 1'b0, 1'b1, 32'h55, 4'd5, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        step(1'b0, (i == 1), (i % 2 == 0), $urandom, 4'($urandom_range(0, 15)),
             (i % 2 == 1), $urandom, 4'($urandom_range(0, 15)));
      else idle();
      tests_run++;
      if ({cdb_ready, cdb_src, cdb_id, cdb_val} !== {1'b1, 1'b0, 4'd5, 32'h55}) begin
        tests_failed++;
        $display("FAIL rdy_frozen[%0d]: got rdy=%0b src=%0b id=%0h val=%h, expected 1 0 5 55", i, cdb_ready, cdb_src, cdb_id, cdb_val);
      end
    end
    idle();
    tests_run++;
    if ({cdb_ready, cdb_val, alu_full, mem_full} !== {1'b0, 32'h55, 2'b00}) begin
      tests_failed++;
      $display("FAIL rdy_nothing_queued: got rdy=%0b val=%h full=%b, expected 0 55 00", cdb_ready, cdb_val, {alu_full, mem_full});
    end
  endtask

  task automatic test_overflow();
    foreach (mem_seen[i]) mem_seen[i] = 1'b0;
    m_mem_dropped = 1'b0;
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b1, $urandom, 4'($urandom_range(0, 15)), 1'b1, 32'hC00 + i, 4'(i));
    idle();
    tests_run++;
    if (err_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_flag: got %0b, expected 1", err_overflow);
    end
    repeat (12) idle();
    tests_run++;
    if ({cdb_ready, err_overflow} !== 2'b01) begin
      tests_failed++;
      $display("FAIL overflow_sticky: got rdy=%0b err=%0b, expected 0 1", cdb_ready, err_overflow);
    end
    if (m_mem_dropped) begin
      tests_run++;
      if (mem_seen[m_mem_drop_id] !== 1'b0) begin
        tests_failed++;
        $display("FAIL overflow_dropped_id: id %0h seen=%0b, expected 0", m_mem_drop_id, mem_seen[m_mem_drop_id]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b1, 32'h77, 4'd7, 1'b0, '0, '0);
    idle();
    tests_run++;
    if ({cdb_ready, cdb_val} !== {1'b1, 32'h77}) begin
      tests_failed++;
      $display("FAIL pre_reset: got rdy=%0b val=%h, expected 1 77", cdb_ready, cdb_val);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({cdb_ready, cdb_src, cdb_id, cdb_val, alu_full, mem_full, err_overflow} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got rdy=%0b src=%0b id=%0h val=%h afull=%0b mfull=%0b err=%0b, expected all 0",
               cdb_ready, cdb_src, cdb_id, cdb_val, alu_full, mem_full, err_overflow);
    end
    model_reset();
    @(negedge clk); #1 rst = 1'b0;
    idle();
    tests_run++;
    if (cdb_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %0b, expected 0", cdb_ready);
    end
  endtask

  initial begin
    m_mem_dropped = 1'b0;
    m_mem_drop_id = '0;
    foreach (mem_seen[i]) mem_seen[i] = 1'b0;
    test_reset();
    test_simultaneous();
    test_alu_bypass();
    test_contention();
    test_flush();
    test_rdy_gating();
    test_overflow();
    test_async_reset();
    test_simultaneous();
    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
